div_unit: RTL and testbench

- Multi-cycle RV32M divider: DIV, DIVU, REM, REMU using radix-2 restoring division, one quotient bit per cycle.
- Sits in the execute stage and generates the div_stall signal consumed by the PC register and the pipeline registers.
- While a division is in flight, div_stall freezes the front end. The result is presented with done for exactly one cycle.

---
 rtl/div_unit.sv | 141 ++++++++++++++
 tb/tb_div_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// Raises div_stall while a divide is in flight and pulses done with the registered result.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             div_stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             sel_rem;
    logic             neg_q;
    logic             neg_r;
    logic             done_r;

    // Magnitude of a two's-complement value; the most-negative input yields 2^(WIDTH-1) as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] n;
        n = -x;
        return x[WIDTH-1] ? WIDTH'(n) : WIDTH'(x);
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    logic             is_signed;
    logic             accept;
    logic             div_zero;
    logic             sgn_ovf;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] special;

    assign is_signed = ~op[0];
    assign accept    = (state == IDLE) & start & ~flush;
    assign div_zero  = (divisor == '0);
    assign sgn_ovf   = is_signed & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor);
    assign special   = div_zero ? (op[1] ? dividend : '1)
                                : (op[1] ? '0 : dividend);

    // One restoring step: shift {rem,quo}, subtract when the divisor fits.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign ge     = (rem_sh >= {1'b0, dvsr});
    assign diff   = rem_sh[WIDTH-1:0] - dvsr;
    assign rem_nx = ge ? diff : rem_sh[WIDTH-1:0];
    assign quo_nx = {quo[WIDTH-2:0], ge};

    always_comb begin
        div_stall = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    div_stall = start & ~flush;
                CALC:    div_stall = ~flush;
                default: div_stall = 1'b0;
            endcase
        end
    end

    assign done = done_r & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            sel_rem <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            done_r  <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (accept) begin
                        sel_rem <= op[1];
                        neg_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r   <= is_signed & dividend[WIDTH-1];
                        quo     <= is_signed ? abs_val(dividend) : dividend;
                        dvsr    <= is_signed ? abs_val(divisor) : divisor;
                        if (div_zero | sgn_ovf) begin
                            result <= special;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            rem   <= '0;
                            cnt   <= CNT_W'(WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state  <= IDLE;
                        done_r <= 1'b0;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            // Sign fix-up is folded into the final iteration.
                            result <= sel_rem ? cond_neg(rem_nx, neg_r) : cond_neg(quo_nx, neg_q);
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, stall count, results, special cases, flush and async reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        div_stall;
    logic        done;
    logic [31:0] result;

    int n_vec  = 0;
    int n_fail = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .div_stall(div_stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one divide at a negedge (cycle 0), hold start until done, then release it.
    task automatic run_div(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        int stalls;
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b;
        #1;
        cyc = 0; stalls = 0;
        while (!done && cyc < 100) begin
            if (div_stall) stalls++;
            @(negedge clk);
            #1;
            cyc++;
        end
        check({tag, " timeout"}, 32'(cyc < 100), 32'd1);
        check({tag, " stall"}, 32'(div_stall), 32'd0);
        check({tag, " stalls"}, 32'(stalls), 32'(exp_lat));
        check({tag, " done_cyc"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
        start = 1'b0;
        @(negedge clk);
        #1;
        check({tag, " done_low"}, 32'(done), 32'd0);
        check({tag, " hold"}, result, exp_res);
    endtask

    initial begin
        int seen_done;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0; flush = 1'b0;
        #1;
        check("rst_stall_start0", 32'(div_stall), 32'd0);
        start = 1'b1;
        #1;
        check("rst_stall_start1", 32'(div_stall), 32'd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);

        run_div("divu_100_7",   2'b01, 32'd100,      32'd7,          32'd14,       33);
        run_div("div_m20_3",    2'b00, 32'hFFFFFFEC, 32'd3,          32'hFFFFFFFA, 33);
        run_div("rem_m20_3",    2'b10, 32'hFFFFFFEC, 32'd3,          32'hFFFFFFFE, 33);
        run_div("remu_big_3",   2'b11, 32'hFFFFFFEC, 32'd3,          32'h00000002, 33);
        run_div("div_7_m2",     2'b00, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD, 33);
        run_div("div_min_3",    2'b00, 32'h80000000, 32'd3,          32'hD5555556, 33);
        run_div("rem_min_3",    2'b10, 32'h80000000, 32'd3,          32'hFFFFFFFE, 33);
        run_div("divu_5_0",     2'b01, 32'd5,        32'd0,          32'hFFFFFFFF, 1);
        run_div("remu_5_0",     2'b11, 32'd5,        32'd0,          32'd5,        1);
        run_div("div_ovf",      2'b00, 32'h80000000, 32'hFFFFFFFF,   32'h80000000, 1);
        run_div("rem_ovf",      2'b10, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 1);
        run_div("rem_m20_0",    2'b10, 32'hFFFFFFEC, 32'd0,          32'hFFFFFFEC, 1);

        // Flush at CALC cycle 10; result must keep the previous value.
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd7;
        repeat (10) @(negedge clk);
        flush = 1'b1; start = 1'b0;
        #1;
        check("flush_stall", 32'(div_stall), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (done) seen_done++;
            @(negedge clk);
        end
        check("flush_no_done", 32'(seen_done), 32'd0);
        check("flush_result", result, 32'hFFFFFFEC);
        run_div("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        // Asynchronous reset in the middle of CALC cycle 12.
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd12345; divisor = 32'd11;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stall", 32'(div_stall), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", result, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_div("divu_max_1", 2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
